whack_round_controller: RTL and testbench

Game sequencer for the whack-a-mole design. It picks mole positions from an internal LFSR and times each mole window. It judges each user guess against the mole and tracks score and lives. Its outputs drive the LED display block directly: mole position, one-cycle right/wrong pulses and the game-over level. It also exports score and lives to the scoreboard.

---
 rtl/whack_round_controller.sv | 142 ++++++++++++++
 tb/tb_whack_round_controller.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/whack_round_controller.sv
// rtl/whack_round_controller.sv - whack-a-mole round sequencer: LFSR mole pick, window timing, score and lives
module whack_round_controller #(
  parameter int unsigned ROUND_TICKS = 10000,
  parameter int unsigned GAP_TICKS   = 2000,
  parameter int unsigned STEP_TICKS  = 500,
  parameter int unsigned MIN_TICKS   = 2500,
  parameter int unsigned LIVES       = 3
) (
  input  logic       i_clk,
  input  logic       i_restart_game,
  input  logic       i_start,
  input  logic       i_guess_valid,
  input  logic [2:0] i_user_guess,
  output logic [2:0] o_mole_position,
  output logic       o_user_right,
  output logic       o_user_wrong,
  output logic       o_game_over,
  output logic [7:0] o_score,
  output logic [1:0] o_lives,
  output logic       o_round_active
);

  typedef enum logic [1:0] {IDLE, GAP, SHOW, OVER} state_t;

  localparam logic [27:0] ROUND_W  = 28'(ROUND_TICKS);
  localparam logic [27:0] GAP_LAST = 28'(GAP_TICKS - 1);
  localparam logic [27:0] STEP_W   = 28'(STEP_TICKS);
  localparam logic [27:0] MIN_W    = 28'(MIN_TICKS);
  localparam logic [1:0]  LIVES_W  = 2'(LIVES);

  state_t      state_q, state_d;
  logic [2:0]  lfsr_q, lfsr_d;
  logic [27:0] timer_q, timer_d;
  logic [27:0] window_q, window_d;
  logic [7:0]  score_q, score_d;
  logic [1:0]  lives_q, lives_d;
  logic [2:0]  mole_q, mole_d;
  logic        right_q, right_d;
  logic        wrong_q, wrong_d;
  logic        over_q, over_d;
  logic        active_q, active_d;
  logic        miss;

  always_comb begin
    state_d  = state_q;
    lfsr_d   = {lfsr_q[1:0], lfsr_q[2] ^ lfsr_q[1]};
    timer_d  = timer_q;
    window_d = window_q;
    score_d  = score_q;
    lives_d  = lives_q;
    mole_d   = mole_q;
    right_d  = 1'b0;
    wrong_d  = 1'b0;
    miss     = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_start) begin
          state_d = GAP;
          timer_d = '0;
          mole_d  = 3'd0;
        end
      end
      GAP: begin
        if (timer_q == GAP_LAST) begin
          state_d = SHOW;
          timer_d = '0;
          mole_d  = lfsr_q;
        end else begin
          timer_d = timer_q + 28'd1;
        end
      end
      SHOW: begin
        // A guess on the last window cycle takes priority over the timeout.
        if (i_guess_valid) begin
          if (i_user_guess == mole_q) begin
            right_d = 1'b1;
            if (score_q != 8'hFF) score_d = score_q + 8'd1;
            window_d = (window_q >= MIN_W + STEP_W) ? window_q - STEP_W : MIN_W;
            state_d  = GAP;
            timer_d  = '0;
            mole_d   = 3'd0;
          end else begin
            miss = 1'b1;
          end
        end else if (timer_q == window_q - 28'd1) begin
          miss = 1'b1;
        end else begin
          timer_d = timer_q + 28'd1;
        end
        if (miss) begin
          wrong_d = 1'b1;
          lives_d = lives_q - 2'd1;
          mole_d  = 3'd0;
          timer_d = '0;
          state_d = (lives_q <= 2'd1) ? OVER : GAP;
        end
      end
      OVER: begin
      end
      default: state_d = IDLE;
    endcase
    active_d = (state_d == SHOW);
    over_d   = (state_d == OVER);
  end

  always_ff @(posedge i_clk) begin
    if (i_restart_game) begin
      state_q  <= IDLE;
      lfsr_q   <= 3'b001;
      timer_q  <= '0;
      window_q <= ROUND_W;
      score_q  <= '0;
      lives_q  <= LIVES_W;
      mole_q   <= 3'd0;
      right_q  <= 1'b0;
      wrong_q  <= 1'b0;
      over_q   <= 1'b0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      timer_q  <= timer_d;
      window_q <= window_d;
      score_q  <= score_d;
      lives_q  <= lives_d;
      mole_q   <= mole_d;
      right_q  <= right_d;
      wrong_q  <= wrong_d;
      over_q   <= over_d;
      active_q <= active_d;
    end
  end

  assign o_mole_position = mole_q;
  assign o_user_right    = right_q;
  assign o_user_wrong    = wrong_q;
  assign o_game_over     = over_q;
  assign o_score         = score_q;
  assign o_lives         = lives_q;
  assign o_round_active  = active_q;

endmodule

// File: tb/tb_whack_round_controller.sv
// tb/tb_whack_round_controller.sv - directed bench for whack_round_controller
module tb_whack_round_controller;

  logic       clk = 1'b0;
  logic       restart = 1'b0;
  logic       start = 1'b0;
  logic       gvalid = 1'b0;
  logic [2:0] guess = 3'd0;
  logic [2:0] mole;
  logic       right, wrong, game_over, active;
  logic [7:0] score;
  logic [1:0] lives;

  int checks = 0;
  int failures = 0;

  logic [2:0] lfsr_m = 3'b001;
  logic [2:0] lfsr_prev_m = 3'b001;
  logic [2:0] mole_exp;
  logic [2:0] bad_guess;

  whack_round_controller #(
    .ROUND_TICKS(20), .GAP_TICKS(5), .STEP_TICKS(4), .MIN_TICKS(8), .LIVES(3)
  ) dut (
    .i_clk(clk),
    .i_restart_game(restart),
    .i_start(start),
    .i_guess_valid(gvalid),
    .i_user_guess(guess),
    .o_mole_position(mole),
    .o_user_right(right),
    .o_user_wrong(wrong),
    .o_game_over(game_over),
    .o_score(score),
    .o_lives(lives),
    .o_round_active(active)
  );

  always #5 clk = ~clk;

  // Reference LFSR; lfsr_prev_m is the value the DUT saw at the latest edge.
  always @(posedge clk) begin
    lfsr_prev_m <= lfsr_m;
    if (restart) lfsr_m <= 3'b001;
    else         lfsr_m <= {lfsr_m[1:0], lfsr_m[2] ^ lfsr_m[1]};
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic step_n(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_mole"},  32'(mole), 0);
    chk({tag, "_score"}, 32'(score), 0);
    chk({tag, "_lives"}, 32'(lives), 3);
    chk({tag, "_right"}, 32'(right), 0);
    chk({tag, "_wrong"}, 32'(wrong), 0);
    chk({tag, "_over"},  32'(game_over), 0);
    chk({tag, "_act"},   32'(active), 0);
  endtask

  initial begin
    int w;
    int rbad;
    int held;

    restart = 1'b1;
    step();
    restart = 1'b0;
    chk_idle_outputs("reset");

    // Timeouts only: three wrong pulses 25 cycles apart, then game over.
    start = 1'b1;
    step();
    start = 1'b0;
    chk("t1_gap_mole", 32'(mole), 0);
    chk("t1_gap_act", 32'(active), 0);
    for (int r = 0; r < 3; r++) begin
      step_n(5);
      chk("t1_show_act", 32'(active), 1);
      chk("t1_show_mole", 32'(mole), 32'(lfsr_prev_m));
      if (r == 0) chk("t1_first_mole", 32'(mole), 6);
      step_n(19);
      chk("t1_last_act", 32'(active), 1);
      chk("t1_last_wrong", 32'(wrong), 0);
      step();
      chk("t1_wrong", 32'(wrong), 1);
      chk("t1_right", 32'(right), 0);
      chk("t1_lives", 32'(lives), 32'(2 - r));
      chk("t1_mole0", 32'(mole), 0);
      chk("t1_over", 32'(game_over), (r == 2) ? 1 : 0);
    end
    held = 1;
    start = 1'b1;
    for (int i = 0; i < 100; i++) begin
      step();
      start = 1'b0;
      if (game_over !== 1'b1 || active !== 1'b0 || wrong !== 1'b0) held = 0;
    end
    chk("t1_over_held", 32'(held), 1);
    chk("t1_over_lives", 32'(lives), 0);

    // Correct guess on the last window cycle: windows 20,16,12,8,8.
    restart = 1'b1;
    step();
    restart = 1'b0;
    chk_idle_outputs("t2_reset");
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      w = (20 - 4 * k < 8) ? 8 : 20 - 4 * k;
      step_n(5);
      mole_exp = lfsr_prev_m;
      chk("t2_mole", 32'(mole), 32'(mole_exp));
      chk("t2_mole_nz", 32'(mole != 3'd0), 1);
      step_n(w - 1);
      chk("t2_act_last", 32'(active), 1);
      gvalid = 1'b1;
      guess = mole_exp;
      step();
      gvalid = 1'b0;
      chk("t2_right", 32'(right), 1);
      chk("t2_wrong", 32'(wrong), 0);
      chk("t2_score", 32'(score), 32'(k + 1));
      chk("t2_lives", 32'(lives), 3);
      chk("t2_mole0", 32'(mole), 0);
    end

    // Wrong guess, then a guess during GAP is ignored.
    step_n(5);
    mole_exp = lfsr_prev_m;
    bad_guess = (mole_exp == 3'd7) ? 3'd1 : mole_exp + 3'd1;
    gvalid = 1'b1;
    guess = bad_guess;
    step();
    gvalid = 1'b0;
    chk("t3_wrong", 32'(wrong), 1);
    chk("t3_right", 32'(right), 0);
    chk("t3_lives", 32'(lives), 2);
    chk("t3_mole0", 32'(mole), 0);
    gvalid = 1'b1;
    guess = mole_exp;
    step();
    gvalid = 1'b0;
    chk("t3_gap_wrong", 32'(wrong), 0);
    chk("t3_gap_right", 32'(right), 0);
    chk("t3_gap_lives", 32'(lives), 2);
    chk("t3_gap_score", 32'(score), 5);
    step_n(4);
    chk("t5_show_act", 32'(active), 1);
    chk("t5_pre_score", 32'(score), 5);

    // Restart mid-SHOW with start and a correct guess in the same cycle.
    restart = 1'b1;
    start = 1'b1;
    gvalid = 1'b1;
    guess = lfsr_prev_m;
    step();
    restart = 1'b0;
    start = 1'b0;
    gvalid = 1'b0;
    chk_idle_outputs("t5_restart");
    step_n(10);
    chk("t5_still_idle", 32'(active), 0);
    start = 1'b1;
    step();
    start = 1'b0;
    step_n(4);
    chk("t5_gap_act", 32'(active), 0);
    step();
    chk("t5_show_act2", 32'(active), 1);
    chk("t5_show_mole", 32'(mole), 32'(lfsr_prev_m));

    // 300 fast hits: score saturates, window stays at the floor.
    rbad = 0;
    for (int i = 0; i < 300; i++) begin
      if (i > 0) step_n(5);
      gvalid = 1'b1;
      guess = lfsr_prev_m;
      step();
      gvalid = 1'b0;
      if (right !== 1'b1 || wrong !== 1'b0) rbad++;
      if (i == 253) chk("t6_score_254", 32'(score), 254);
      if (i == 255) chk("t6_score_sat", 32'(score), 255);
    end
    chk("t6_all_right", 32'(rbad), 0);
    chk("t6_score_final", 32'(score), 255);
    chk("t6_lives", 32'(lives), 3);
    step_n(5);
    chk("t6_show_act", 32'(active), 1);
    step_n(7);
    chk("t6_min_act", 32'(active), 1);
    step();
    chk("t6_min_wrong", 32'(wrong), 1);
    chk("t6_min_lives", 32'(lives), 2);
    chk("t6_min_score", 32'(score), 255);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
